// File: rtl/unidade_controle_if.sv
// Signal bundle between the game control unit and its datapath: status
// inputs toward the FSM, counter/register controls and end flags back out.
interface unidade_controle_if;
   logic       iniciar;
   logic       jogada_feita;
   logic       igual;
   logic       fimRodada;
   logic       fimTotal;
   logic       fimT;
   logic       zeraCL;
   logic       contaCL;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       conta;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic [4:0] db_estado;

   modport master (
      output iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT,
      input  zeraCL, contaCL, zeraC, contaC, zeraR, registraR, conta,
      input  pronto, acertou, errou, timeout, db_estado
   );

   modport slave (
      input  iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT,
      output zeraCL, contaCL, zeraC, contaC, zeraR, registraR, conta,
      output pronto, acertou, errou, timeout, db_estado
   );
endinterface

// File: rtl/unidade_controle.sv
// Moore control FSM for the memory game: sequences rounds and plays and
// reports win, error or timeout; all outputs decode from the state register.
module unidade_controle (
   input  logic                clock,
   input  logic                reset,
   unidade_controle_if.slave   bus
);

   typedef enum logic [4:0] {
      inicial        = 5'b00000,
      preparacao     = 5'b00001,
      inicio_rodada  = 5'b00010,
      espera_jogada  = 5'b00011,
      registra       = 5'b00100,
      comparacao     = 5'b00101,
      proxima_jogada = 5'b00110,
      proxima_rodada = 5'b00111,
      fim_acerto     = 5'b01010,
      fim_erro       = 5'b01110,
      fim_timeout    = 5'b01101
   } estado_t;

   estado_t r_estado;
   estado_t w_proximo;

   logic w_zeraCL, w_contaCL, w_zeraC, w_contaC, w_zeraR, w_registraR;
   logic w_conta, w_pronto, w_acertou, w_errou, w_timeout;

   always_ff @(posedge clock) begin
      if (!reset)
         r_estado <= inicial;
      else
         r_estado <= w_proximo;
   end

   // A key press beats a simultaneous timeout while waiting for a play.
   always_comb begin
      w_proximo = inicial;
      case (r_estado)
         inicial:        w_proximo = bus.iniciar ? preparacao : inicial;
         preparacao:     w_proximo = inicio_rodada;
         inicio_rodada:  w_proximo = espera_jogada;
         espera_jogada: begin
            if (bus.jogada_feita)
               w_proximo = registra;
            else if (bus.fimT)
               w_proximo = fim_timeout;
            else
               w_proximo = espera_jogada;
         end
         registra:       w_proximo = comparacao;
         comparacao: begin
            if (!bus.igual)
               w_proximo = fim_erro;
            else if (bus.fimRodada && bus.fimTotal)
               w_proximo = fim_acerto;
            else if (bus.fimRodada)
               w_proximo = proxima_rodada;
            else
               w_proximo = proxima_jogada;
         end
         proxima_jogada: w_proximo = espera_jogada;
         proxima_rodada: w_proximo = inicio_rodada;
         fim_acerto:     w_proximo = bus.iniciar ? preparacao : fim_acerto;
         fim_erro:       w_proximo = bus.iniciar ? preparacao : fim_erro;
         fim_timeout:    w_proximo = bus.iniciar ? preparacao : fim_timeout;
         default:        w_proximo = inicial;
      endcase
   end

   always_comb begin
      w_zeraCL    = 1'b0;
      w_contaCL   = 1'b0;
      w_zeraC     = 1'b0;
      w_contaC    = 1'b0;
      w_zeraR     = 1'b0;
      w_registraR = 1'b0;
      w_conta     = 1'b0;
      w_pronto    = 1'b0;
      w_acertou   = 1'b0;
      w_errou     = 1'b0;
      w_timeout   = 1'b0;
      case (r_estado)
         preparacao: begin
            w_zeraCL = 1'b1;
            w_zeraC  = 1'b1;
            w_zeraR  = 1'b1;
         end
         inicio_rodada: begin
            w_zeraC = 1'b1;
            w_zeraR = 1'b1;
         end
         espera_jogada:  w_conta     = 1'b1;
         registra:       w_registraR = 1'b1;
         proxima_jogada: w_contaC    = 1'b1;
         proxima_rodada: w_contaCL   = 1'b1;
         fim_acerto: begin
            w_pronto  = 1'b1;
            w_acertou = 1'b1;
         end
         fim_erro: begin
            w_pronto = 1'b1;
            w_errou  = 1'b1;
         end
         fim_timeout: begin
            w_pronto  = 1'b1;
            w_timeout = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.zeraCL    = w_zeraCL;
   assign bus.contaCL   = w_contaCL;
   assign bus.zeraC     = w_zeraC;
   assign bus.contaC    = w_contaC;
   assign bus.zeraR     = w_zeraR;
   assign bus.registraR = w_registraR;
   assign bus.conta     = w_conta;
   assign bus.pronto    = w_pronto;
   assign bus.acertou   = w_acertou;
   assign bus.errou     = w_errou;
   assign bus.timeout   = w_timeout;
   assign bus.db_estado = r_estado;

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have no parameters; all timing is fixed by the state machine below.
REQ-002 clock  input  1  system clock; all state changes SHALL occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
REQ-004 iniciar  input  1  start/restart request, level-sampled.
REQ-005 jogada_feita  input  1  one-cycle pulse from the datapath edge detector: a key press occurred.
REQ-006 igual  input  1  registered play equals the ROM value at the current address.
REQ-007 fimRodada  input  1  the play address equals the current round index.
REQ-008 fimTotal  input  1  the round index equals the last round for the selected mode.
REQ-009 fimT  input  1  the play timeout counter has expired.
REQ-010 zeraCL, contaCL  output  1 each  clear / increment for the round counter.
REQ-011 zeraC, contaC  output  1 each  clear / increment for the play-address counter.
REQ-012 zeraR, registraR  output  1 each  clear / load for the play register.
REQ-013 conta  output  1  enable for the timeout counter.
REQ-014 pronto, acertou, errou, timeout  output  1 each  end-of-game flags.
REQ-015 db_estado  output  5  current state code, for debug display.

Function
REQ-016 The block SHALL be a Moore FSM, and every output SHALL decode from the state register only; any output not listed for a state SHALL be 0.
REQ-017 States and codes: inicial=00000, preparacao=00001, inicio_rodada=00010, espera_jogada=00011, registra=00100, comparacao=00101, proxima_jogada=00110, proxima_rodada=00111, fim_acerto=01010, fim_erro=01110, fim_timeout=01101; db_estado SHALL equal the current code.
REQ-018 inicial: all outputs 0; go to preparacao when iniciar=1, otherwise stay.
REQ-019 preparacao: zeraCL=zeraC=zeraR=1; go unconditionally to inicio_rodada.
REQ-020 inicio_rodada: zeraC=zeraR=1; go unconditionally to espera_jogada.
REQ-021 espera_jogada: conta=1; jogada_feita=1 goes to registra; else fimT=1 goes to fim_timeout; else stay.
REQ-022 If jogada_feita and fimT are both 1 in the same cycle, jogada_feita SHALL win and the next state SHALL be registra.
REQ-023 registra: registraR=1; go to comparacao. This extra cycle covers the synchronous ROM and register latency.
REQ-024 comparacao transitions, in priority order:
  - igual=0 goes to fim_erro;
  - else fimRodada=1 and fimTotal=1 goes to fim_acerto;
  - else fimRodada=1 goes to proxima_rodada;
  - else goes to proxima_jogada.
REQ-025 proxima_jogada: contaC=1; go to espera_jogada.
REQ-026 proxima_rodada: contaCL=1; go to inicio_rodada.
REQ-027 fim_acerto SHALL assert pronto=1 and acertou=1.
REQ-028 fim_erro SHALL assert pronto=1 and errou=1.
REQ-029 fim_timeout SHALL assert pronto=1 and timeout=1.
REQ-030 Each end state SHALL hold until iniciar=1, then go to preparacao; there is no path back to inicial except reset.
REQ-031 iniciar SHALL be ignored in every state except inicial and the three end states.
REQ-032 Unused state codes SHALL transition to inicial on the next edge.
REQ-033 Latency from jogada_feita (in espera_jogada) to the comparison decision SHALL be exactly 2 cycles: registra, then comparacao.

Reset
REQ-034 reset=0 at a rising edge SHALL force inicial regardless of state or inputs, including mid-round; outputs SHALL then be all 0 and db_estado=00000.
REQ-035 While reset=0 the FSM SHALL remain in inicial even if iniciar=1.

Verification
REQ-036 Reset then idle: reset=0 for 2 cycles, then reset=1 with iniciar=0 -> db_estado=00000 and all outputs 0 for 10 cycles.
REQ-037 Full win, 4 rounds: iniciar pulse, then correct plays (igual=1) with fimRodada/fimTotal driven per round -> state sequence 1,2,3,4,5,6 repeats as expected, 4 contaCL pulses are never exceeded, and the run ends with db_estado=01010, pronto=1, acertou=1.
REQ-038 Error: in round 2, first play with igual=0 -> comparacao goes to fim_erro, errou=1, pronto=1, and contaC is never asserted after that play.
REQ-039 Timeout: in espera_jogada hold jogada_feita=0 and raise fimT -> next state fim_timeout, timeout=1, conta drops to 0.
REQ-040 Simultaneous events and restart:
  - jogada_feita=fimT=1 in the same cycle -> next state registra (00100);
  - from fim_erro, iniciar=1 -> preparacao with zeraCL=zeraC=zeraR=1.
REQ-041 Mid-operation reset: reset=0 while in comparacao -> inicial on the next edge, all outputs 0.
